ram_port_arbiter: RTL and testbench

- Shares the single-port 1024x32 data RAM wrapper between two requesters.
  - Port 0: SOC data bus.
  - Port 1: a DMA/VGA-side reader/writer.
- Round-robin arbitration with a registered command stage drives the RAM write-enable, address and write data.
- Read data is routed back to the winning requester with a fixed latency.
- Sits between the SOC RAM-device port and the RAM wrapper in the top-level.

---
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port synchronous-read RAM between two requesters
// (port 0: SOC data bus, port 1: DMA/VGA side). Every cycle at most one
// eligible requester wins. The winning command is registered onto the RAM
// pins, a one-cycle grant pulse goes back to the winner, and read data is
// returned one cycle after the grant.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   pX_req/we/addr/wdata  : request from port X, held until pX_gnt
//   pX_gnt                : one-cycle grant / write acknowledge
//   pX_rvalid             : one-cycle read-data-valid pulse (cycle after gnt)
//   pX_rdata              : RAM read data, unregistered pass-through
//   ram_we/addra/dina     : registered command to the RAM wrapper
//   ram_douta             : RAM read data (valid one cycle after address)
//
// Parameters
//   ADDR_W, DATA_W        : RAM word-address and data width
//   FIXED_PRIO            : 1 = port 0 wins every tie, 0 = round-robin
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta
);

    // Command stage
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    // Port that won the most recent arbitration (1 after reset so port 0
    // takes the first tie).
    logic              last_q, last_d;
    // Read-return tag stage: a read is in the RAM, and which port owns it.
    logic              rd_pend_q, rd_pend_d;
    logic              rd_id_q, rd_id_d;

    // Arbitration
    logic              elig0, elig1;
    logic              win_valid;
    logic              win_sel;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    always_comb begin
        // A port whose grant is high this cycle has already been issued;
        // masking it stops the still-held request from being issued twice.
        elig0 = p0_req & ~gnt0_q;
        elig1 = p1_req & ~gnt1_q;

        win_valid = elig0 | elig1;
        if (elig0 && elig1) begin
            win_sel = FIXED_PRIO ? 1'b0 : ~last_q;
        end else begin
            win_sel = elig1;
        end

        win_we    = win_sel ? p1_we    : p0_we;
        win_addr  = win_sel ? p1_addr  : p0_addr;
        win_wdata = win_sel ? p1_wdata : p0_wdata;

        gnt0_d   = win_valid & ~win_sel;
        gnt1_d   = win_valid &  win_sel;
        ram_we_d = win_valid &  win_we;
        addr_d   = win_valid ? win_addr  : addr_q;
        din_d    = win_valid ? win_wdata : din_q;
        last_d   = win_valid ? win_sel   : last_q;

        // The RAM returns data one cycle after the address, so a read that is
        // on the RAM pins now is returned to its owner next cycle.
        rd_pend_d = (gnt0_q | gnt1_q) & ~ram_we_q;
        rd_id_d   = gnt1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            ram_we_q  <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            ram_we_q  <= ram_we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign p0_gnt    = gnt0_q;
    assign p1_gnt    = gnt1_q;
    assign p0_rvalid = rd_pend_q & ~rd_id_q;
    assign p1_rvalid = rd_pend_q &  rd_id_q;
    assign p0_rdata  = ram_douta;
    assign p1_rdata  = ram_douta;

    assign ram_we    = ram_we_q;
    assign ram_addra = addr_q;
    assign ram_dina  = din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Two arbiter instances (round-robin and fixed-priority) share the requester
// inputs; each drives its own behavioural RAM (synchronous, read-first).
// Directed scenarios cover reset, single read, write-then-read, continuous
// contention, tie-breaking, request hold and mid-operation reset. A random
// scenario checks every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [9:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we;
    logic [31:0] p0_rdata, p1_rdata, ram_dina, douta_rr;
    logic [9:0]  ram_addra;

    logic        fp_p0_gnt, fp_p0_rvalid, fp_p1_gnt, fp_p1_rvalid, fp_ram_we;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_ram_dina, douta_fp;
    logic [9:0]  fp_ram_addra;

    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    logic [31:0] mem_rr [0:1023];
    logic [31:0] mem_fp [0:1023];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_we(ram_we), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_douta(douta_rr)
    );

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
        .ram_we(fp_ram_we), .ram_addra(fp_ram_addra), .ram_dina(fp_ram_dina),
        .ram_douta(douta_fp)
    );

    // Behavioural RAMs: synchronous read, old data on read-during-write.
    always @(posedge clk) begin
        if (pre_we) mem_rr[pre_addr] <= pre_data;
        else if (ram_we) mem_rr[ram_addra] <= ram_dina;
        douta_rr <= mem_rr[ram_addra];
    end

    always @(posedge clk) begin
        if (pre_we) mem_fp[pre_addr] <= pre_data;
        else if (fp_ram_we) mem_fp[fp_ram_addra] <= fp_ram_dina;
        douta_fp <= mem_fp[fp_ram_addra];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    // Leaves the bench in cycle 0: first cycle with reset released.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b, want 00000", {p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we});
        end else pass_cnt++;
        chk_cnt++;
        if ({ram_addra, ram_dina} !== 42'h0) begin
            $display("FAIL reset_cmd: got addr 0x%03h din 0x%08h, want 0", ram_addra, ram_dina);
        end else pass_cnt++;
        chk_cnt++;
        if ({fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid, fp_ram_we, fp_ram_addra, fp_ram_dina} !== 47'h0) begin
            $display("FAIL reset_fp: outputs not all zero");
        end else pass_cnt++;
    endtask

    task automatic test_single_read();
        logic p1_seen = 1'b0;
        preload(10'h005, 32'hDEADBEEF);
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 10'h005;
        tick(); // cycle 1
        p1_seen |= p1_gnt | p1_rvalid;
        chk_cnt++;
        if ({p0_gnt, ram_we} !== 2'b10 || ram_addra !== 10'h005) begin
            $display("FAIL rd_cmd: got gnt=%b we=%b addr=0x%03h, want gnt=1 we=0 addr=0x005", p0_gnt, ram_we, ram_addra);
        end else pass_cnt++;
        tick(); // cycle 2
        p0_req = 0;
        p1_seen |= p1_gnt | p1_rvalid;
        chk_cnt++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p0_gnt !== 1'b0) begin
            $display("FAIL rd_data: got rvalid=%b rdata=0x%08h gnt=%b, want 1 0xdeadbeef 0", p0_rvalid, p0_rdata, p0_gnt);
        end else pass_cnt++;
        tick(); // cycle 3
        p1_seen |= p1_gnt | p1_rvalid;
        chk_cnt++;
        if (p0_rvalid !== 1'b0 || p0_gnt !== 1'b0) begin
            $display("FAIL rd_single_pulse: got rvalid=%b gnt=%b, want 0 0", p0_rvalid, p0_gnt);
        end else pass_cnt++;
        chk_cnt++;
        if (p1_seen !== 1'b0) begin
            $display("FAIL rd_p1_quiet: got p1 activity %b, want 0", p1_seen);
        end else pass_cnt++;
    endtask

    task automatic test_write_then_read();
        do_reset();
        p1_req = 1; p1_we = 1; p1_addr = 10'h3FF; p1_wdata = 32'h12345678;
        tick(); // cycle 1
        chk_cnt++;
        if ({p1_gnt, p0_gnt, ram_we} !== 3'b101 || ram_addra !== 10'h3FF || ram_dina !== 32'h12345678) begin
            $display("FAIL wr_cmd: got gnt1=%b gnt0=%b we=%b addr=0x%03h din=0x%08h, want 1 0 1 0x3ff 0x12345678",
                     p1_gnt, p0_gnt, ram_we, ram_addra, ram_dina);
        end else pass_cnt++;
        tick(); // cycle 2
        p1_req = 0; p1_we = 0;
        p0_req = 1; p0_we = 0; p0_addr = 10'h3FF;
        chk_cnt++;
        if (ram_we !== 1'b0 || p1_rvalid !== 1'b0) begin
            $display("FAIL wr_one_cycle: got we=%b p1_rvalid=%b, want 0 0", ram_we, p1_rvalid);
        end else pass_cnt++;
        tick(); // cycle 3
        chk_cnt++;
        if (p0_gnt !== 1'b1 || ram_addra !== 10'h3FF) begin
            $display("FAIL raw_gnt: got gnt=%b addr=0x%03h, want 1 0x3ff", p0_gnt, ram_addra);
        end else pass_cnt++;
        tick(); // cycle 4
        p0_req = 0;
        chk_cnt++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678 || p1_rvalid !== 1'b0) begin
            $display("FAIL raw_data: got rvalid=%b rdata=0x%08h, want 1 0x12345678", p0_rvalid, p0_rdata);
        end else pass_cnt++;
    endtask

    // Both ports read continuously from reset: grants alternate p0,p1,... on
    // both instances, and each read returns on its own port a cycle later.
    task automatic test_both_continuous();
        logic [31:0] da = 32'hA5A50010;
        logic [31:0] db = 32'h5A5A0020;
        int gp, rp;
        preload(10'h010, da);
        preload(10'h020, db);
        do_reset();
        p0_req = 1; p0_addr = 10'h010;
        p1_req = 1; p1_addr = 10'h020;
        for (int i = 1; i <= 6; i++) begin
            tick();
            gp = (i - 1) % 2;
            chk_cnt++;
            if ({p0_gnt, p1_gnt} !== {gp == 0, gp == 1} || {fp_p0_gnt, fp_p1_gnt} !== {gp == 0, gp == 1}) begin
                $display("FAIL cont_gnt cyc%0d: got rr=%b%b fp=%b%b, want port %0d",
                         i, p0_gnt, p1_gnt, fp_p0_gnt, fp_p1_gnt, gp);
            end else pass_cnt++;
            if (i >= 2) begin
                rp = (i - 2) % 2;
                chk_cnt++;
                if ({p0_rvalid, p1_rvalid} !== {rp == 0, rp == 1} ||
                    (rp == 0 ? p0_rdata : p1_rdata) !== (rp == 0 ? da : db)) begin
                    $display("FAIL cont_rvalid cyc%0d: got rv=%b%b data=0x%08h, want port %0d data 0x%08h",
                             i, p0_rvalid, p1_rvalid, (rp == 0 ? p0_rdata : p1_rdata), rp, (rp == 0 ? da : db));
                end else pass_cnt++;
            end
        end
        idle_inputs();
    endtask

    // Tie with port 0 as last winner: round-robin picks p1, fixed picks p0.
    task automatic test_tie_break();
        do_reset();
        p0_req = 1; p0_addr = 10'h001;
        tick(); // cycle 1
        chk_cnt++;
        if (p0_gnt !== 1'b1 || fp_p0_gnt !== 1'b1) begin
            $display("FAIL tie_first: got rr=%b fp=%b, want 1 1", p0_gnt, fp_p0_gnt);
        end else pass_cnt++;
        tick(); // cycle 2
        p0_addr = 10'h002;
        p1_req = 1; p1_addr = 10'h003;
        tick(); // cycle 3
        chk_cnt++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin
            $display("FAIL tie_rr: got gnt0/1=%b%b, want 01", p0_gnt, p1_gnt);
        end else pass_cnt++;
        chk_cnt++;
        if ({fp_p0_gnt, fp_p1_gnt} !== 2'b10) begin
            $display("FAIL tie_fixed: got gnt0/1=%b%b, want 10", fp_p0_gnt, fp_p1_gnt);
        end else pass_cnt++;
        tick(); // cycle 4: the loser of each tie now gets in
        chk_cnt++;
        if ({p0_gnt, p1_gnt} !== 2'b10 || {fp_p0_gnt, fp_p1_gnt} !== 2'b01) begin
            $display("FAIL tie_next: got rr=%b%b fp=%b%b, want 10 01", p0_gnt, p1_gnt, fp_p0_gnt, fp_p1_gnt);
        end else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_single_hold();
        logic [8:0] gnt_mask = '0;
        int we_cnt = 0;
        int orphan = 0;
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 10'h007; p0_wdata = $urandom();
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) p0_req = 0;
            gnt_mask[c] = p0_gnt;
            if (ram_we) we_cnt++;
            if (ram_we && !(p0_gnt || p1_gnt)) orphan++;
        end
        chk_cnt++;
        if (gnt_mask !== 9'b000101010) begin
            $display("FAIL hold_gnts: got cycle mask %b, want 000101010", gnt_mask);
        end else pass_cnt++;
        chk_cnt++;
        if (we_cnt != 3 || orphan != 0) begin
            $display("FAIL hold_writes: got %0d writes %0d without gnt, want 3 and 0", we_cnt, orphan);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        p0_req = 1; p0_addr = 10'h005;
        tick(); // cycle 1: read granted, reset asserted
        chk_cnt++;
        if (p0_gnt !== 1'b1) begin
            $display("FAIL rstmid_pre: got gnt=%b, want 1", p0_gnt);
        end else pass_cnt++;
        reset = 1'b1;
        tick(); // cycle 2
        reset = 1'b0;
        chk_cnt++;
        if ({p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we} !== 5'b0 || {ram_addra, ram_dina} !== 42'h0) begin
            $display("FAIL rstmid_zero: got ctrl=%b addr=0x%03h din=0x%08h, want all 0",
                     {p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we}, ram_addra, ram_dina);
        end else pass_cnt++;
        p0_req = 1; p0_addr = 10'h006;
        p1_req = 1; p1_addr = 10'h007;
        tick(); // cycle 3
        chk_cnt++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b1000) begin
            $display("FAIL rstmid_tie: got gnt=%b%b rvalid=%b%b, want 10 00", p0_gnt, p1_gnt, p0_rvalid, p1_rvalid);
        end else pass_cnt++;
        idle_inputs();
    endtask

    // Random traffic against a transaction-level model. Expected events are
    // scheduled per cycle: {gnt0, gnt1, ram_we, rvalid0, rvalid1}.
    task automatic test_random(input bit fp);
        localparam int N = 300;
        logic [4:0]  exp_ctl   [0:N+2];
        logic        exp_cmd   [0:N+2];
        logic [9:0]  exp_addr  [0:N+2];
        logic [31:0] exp_din   [0:N+2];
        logic [31:0] exp_rdata [0:N+2];
        logic [31:0] shadow    [0:31];
        logic        act [2], twe [2], done [2];
        logic [9:0]  tad [2];
        logic [31:0] twd [2];
        logic [4:0]  obs_ctl;
        logic        e0, e1, w, last_win;
        logic [9:0]  obs_addr;
        logic [31:0] obs_din, obs_rdata;

        reset = 1'b1;
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            shadow[a] = $urandom();
            preload(10'(a), shadow[a]);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k <= N + 2; k++) begin
            exp_ctl[k] = '0; exp_cmd[k] = 1'b0; exp_addr[k] = '0; exp_din[k] = '0; exp_rdata[k] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; twe[p] = 0; done[p] = 0; tad[p] = '0; twd[p] = '0;
        end
        last_win = 1'b1;

        for (int k = 0; k < N; k++) begin
            if (k > 0) tick();
            obs_ctl   = fp ? {fp_p0_gnt, fp_p1_gnt, fp_ram_we, fp_p0_rvalid, fp_p1_rvalid}
                           : {p0_gnt, p1_gnt, ram_we, p0_rvalid, p1_rvalid};
            obs_addr  = fp ? fp_ram_addra : ram_addra;
            obs_din   = fp ? fp_ram_dina  : ram_dina;
            obs_rdata = fp ? (exp_ctl[k][1] ? fp_p0_rdata : fp_p1_rdata)
                           : (exp_ctl[k][1] ? p0_rdata : p1_rdata);
            chk_cnt++;
            if (obs_ctl !== exp_ctl[k]) begin
                $display("FAIL rand%0d_ctl cyc%0d: got gnt/we/rv=%b, want %b", fp, k, obs_ctl, exp_ctl[k]);
            end else pass_cnt++;
            if (exp_cmd[k]) begin
                chk_cnt++;
                if (obs_addr !== exp_addr[k]) begin
                    $display("FAIL rand%0d_addr cyc%0d: got 0x%03h, want 0x%03h", fp, k, obs_addr, exp_addr[k]);
                end else pass_cnt++;
            end
            if (exp_ctl[k][2]) begin
                chk_cnt++;
                if (obs_din !== exp_din[k]) begin
                    $display("FAIL rand%0d_din cyc%0d: got 0x%08h, want 0x%08h", fp, k, obs_din, exp_din[k]);
                end else pass_cnt++;
            end
            if (exp_ctl[k][1] || exp_ctl[k][0]) begin
                chk_cnt++;
                if (obs_rdata !== exp_rdata[k]) begin
                    $display("FAIL rand%0d_rdata cyc%0d: got 0x%08h, want 0x%08h", fp, k, obs_rdata, exp_rdata[k]);
                end else pass_cnt++;
            end

            // Requesters: retire after the gnt cycle, then maybe start anew.
            for (int p = 0; p < 2; p++) begin
                if (done[p]) act[p] = 1'b0;
                if (!act[p] && k < N - 6 && $urandom_range(0, 2) != 0) begin
                    act[p] = 1'b1;
                    twe[p] = 1'($urandom_range(0, 1));
                    tad[p] = 10'($urandom_range(0, 31));
                    twd[p] = $urandom();
                end
                done[p] = act[p] && obs_ctl[4 - p];
            end
            p0_req = act[0]; p0_we = twe[0]; p0_addr = tad[0]; p0_wdata = twd[0];
            p1_req = act[1]; p1_we = twe[1]; p1_addr = tad[1]; p1_wdata = twd[1];

            // Reference model: who gets this cycle's slot.
            e0 = act[0] && !exp_ctl[k][4];
            e1 = act[1] && !exp_ctl[k][3];
            if (e0 || e1) begin
                if (e0 && e1) w = fp ? 1'b0 : (last_win == 1'b1 ? 1'b0 : 1'b1);
                else          w = e1;
                last_win = w;
                exp_ctl[k+1][w ? 3 : 4] = 1'b1;
                exp_cmd[k+1]  = 1'b1;
                exp_addr[k+1] = tad[w];
                exp_din[k+1]  = twd[w];
                if (twe[w]) begin
                    exp_ctl[k+1][2] = 1'b1;
                    shadow[tad[w][4:0]] = twd[w];
                end else begin
                    exp_ctl[k+2][w ? 0 : 1] = 1'b1;
                    exp_rdata[k+2] = shadow[tad[w][4:0]];
                end
                $display("txn prio=%0d cyc=%0d port=%0d %s addr=0x%03h data=0x%08h", fp, k, w,
                         twe[w] ? "WR" : "RD", tad[w], twe[w] ? twd[w] : shadow[tad[w][4:0]]);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_then_read();
        test_both_continuous();
        test_tie_break();
        test_single_hold();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
